capture_ctrl: RTL and testbench



---
 rtl/capture_pkg.sv | 16 +
 rtl/capture_ctrl.sv | 145 ++++++++++++++
 tb/tb_capture_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared types for the scope capture controller.
// Holds the capture FSM state enum and the default RAM address width.
// No logic lives here.
package capture_pkg;

  localparam int ADDR_W_DEFAULT = 9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } cap_state_t;

endpackage

// File: rtl/capture_ctrl.sv
// Capture controller: sequences circular capture-RAM writes around a trigger.
// Latency: state/status outputs registered (1 cycle); we is combinational from smpl_en.
// Backpressure: none; every smpl_en strobe while capturing is one RAM write.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   run, trig_pos     - start pulse and pre-trigger sample count (latched in IDLE)
//   smpl_en           - decimator sample strobe
//   triggered         - trigger level from the trigger logic
//   done_ack          - host has consumed the buffer
//   armed             - pre-trigger region full, waiting for trigger
//   set_capture_done  - one-cycle pulse on entry to DONE (clears trigger latch)
//   capture_done      - capture complete, buffer stable
//   we, waddr         - capture RAM write port
//   trig_addr         - address of first post-trigger sample
//   busy              - controller is not idle
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              smpl_en,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              triggered,
  input  logic              done_ack,
  output logic              armed,
  output logic              set_capture_done,
  output logic              capture_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy
);

  // ENTRIES expressed in the post counter's width (ADDR_W+1 bits).
  localparam logic [ADDR_W:0] ENTRIES_W = {1'b1, {ADDR_W{1'b0}}};

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] trig_pos_q, trig_pos_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
  logic              armed_q, armed_d;
  logic              set_done_q, set_done_d;
  logic              cap_done_q, cap_done_d;
  logic              busy_q, busy_d;
  logic              wr;

  // Writes happen only in the three capturing states; gated by registered state.
  assign wr = smpl_en && (state_q inside {S_PRE, S_ARMED, S_POST});

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    trig_addr_d = trig_addr_q;
    trig_pos_d  = trig_pos_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          trig_pos_d = trig_pos;
          waddr_d    = '0;
          pre_cnt_d  = '0;
          state_d    = (trig_pos == '0) ? S_ARMED : S_PRE;
        end
      end
      S_PRE: begin
        // triggered is deliberately ignored until the pre-trigger region is full.
        if (wr) begin
          waddr_d   = waddr_q + ADDR_W'(1);
          pre_cnt_d = pre_cnt_q + ADDR_W'(1);
          if (pre_cnt_d == trig_pos_q) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (wr) waddr_d = waddr_q + ADDR_W'(1);
        if (triggered) begin
          state_d     = S_POST;
          // trig_pos_q <= ENTRIES-1, so the post count is never zero.
          post_cnt_d  = ENTRIES_W - {1'b0, trig_pos_q};
          // A write in this cycle is still pre-trigger; the next address is the first post sample.
          trig_addr_d = waddr_d;
        end
      end
      S_POST: begin
        if (wr) begin
          waddr_d    = waddr_q + ADDR_W'(1);
          post_cnt_d = post_cnt_q - (ADDR_W+1)'(1);
          if (post_cnt_q == (ADDR_W+1)'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (done_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the next state.
    armed_d    = (state_d == S_ARMED);
    cap_done_d = (state_d == S_DONE);
    set_done_d = (state_d == S_DONE) && (state_q != S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      trig_addr_q <= '0;
      trig_pos_q  <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      armed_q     <= 1'b0;
      set_done_q  <= 1'b0;
      cap_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      trig_addr_q <= trig_addr_d;
      trig_pos_q  <= trig_pos_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      armed_q     <= armed_d;
      set_done_q  <= set_done_d;
      cap_done_q  <= cap_done_d;
      busy_q      <= busy_d;
    end
  end

  assign armed            = armed_q;
  assign set_capture_done = set_done_q;
  assign capture_done     = cap_done_q;
  assign busy             = busy_q;
  assign we               = wr;
  assign waddr            = waddr_q;
  assign trig_addr        = trig_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl with ADDR_W = 4: vector table, directed capture
// sequences and a randomized run checked against a write-count reference model.
module tb_capture_ctrl;
  localparam int AW = 4;
  localparam int E  = 16;

  logic          clk = 1'b0;
  logic          rst, run, smpl_en, triggered, done_ack;
  logic [AW-1:0] trig_pos;
  logic          armed, set_capture_done, capture_done, we, busy;
  logic [AW-1:0] waddr, trig_addr;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // Observations taken in the last tick (after inputs settled, before the edge).
  logic          o_we, o_armed, o_busy, o_sd, o_cd;
  logic [AW-1:0] o_waddr;

  always #5 clk = ~clk;

  capture_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .run(run), .smpl_en(smpl_en), .trig_pos(trig_pos),
    .triggered(triggered), .done_ack(done_ack), .armed(armed),
    .set_capture_done(set_capture_done), .capture_done(capture_done), .we(we),
    .waddr(waddr), .trig_addr(trig_addr), .busy(busy)
  );

  // Reference model: phase plus counts of samples written since run.
  localparam int P_IDLE = 0, P_PRE = 1, P_ARMED = 2, P_POST = 3, P_DONE = 4;
  int m_phase = P_IDLE, m_tp = 0, m_nw = 0, m_npost = 0, m_taddr = 0;
  bit m_sd = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit sd = 0;
    if (rst) begin
      m_phase = P_IDLE; m_tp = 0; m_nw = 0; m_npost = 0; m_taddr = 0;
    end else begin
      case (m_phase)
        P_IDLE:  if (run) begin
                   m_tp = int'(trig_pos); m_nw = 0;
                   m_phase = (m_tp == 0) ? P_ARMED : P_PRE;
                 end
        P_PRE:   if (smpl_en) begin
                   m_nw++;
                   if (m_nw == m_tp) m_phase = P_ARMED;
                 end
        P_ARMED: begin
                   if (smpl_en) m_nw++;
                   if (triggered) begin
                     m_phase = P_POST; m_npost = 0; m_taddr = m_nw % E;
                   end
                 end
        P_POST:  if (smpl_en) begin
                   m_nw++; m_npost++;
                   if (m_npost == E - m_tp) begin m_phase = P_DONE; sd = 1; end
                 end
        default: if (done_ack) m_phase = P_IDLE;
      endcase
    end
    m_sd = sd;
  endtask

  task automatic tick();
    #1;
    o_we = we; o_waddr = waddr; o_armed = armed; o_busy = busy;
    o_sd = set_capture_done; o_cd = capture_done;
    if (chk_en) begin
      chk("armed",        armed,            m_phase == P_ARMED);
      chk("busy",         busy,             m_phase != P_IDLE);
      chk("capture_done", capture_done,     m_phase == P_DONE);
      chk("set_done",     set_capture_done, m_sd);
      chk("waddr",        waddr,            m_nw % E);
      chk("trig_addr",    trig_addr,        m_taddr);
      chk("we",           we,               smpl_en && (m_phase inside {P_PRE, P_ARMED, P_POST}));
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; run = 0; smpl_en = 0; triggered = 0; done_ack = 0; trig_pos = '0;
  endtask

  typedef struct {
    logic rst, run, smpl, trig, ack;
    logic [AW-1:0] tp;
    int   rep;
    logic e_armed, e_busy, e_cd, e_sd;
    logic [AW-1:0] e_waddr, e_taddr;
  } vec_t;

  vec_t tbl[14];

  // One capture driven from observed outputs; triggers after armed_writes ARMED writes.
  task automatic do_capture(input int tp, input int period, input bit trig_in_pre,
                            input int armed_writes, input string tag);
    int pre_w = 0, arm_w = 0, post_w = 0, sd_n = 0, arm_cyc = 0, total = 0;
    int arm_rise_addr = -1;
    bit seen_armed = 0, finished = 0;
    idle_inputs();
    trig_pos = AW'(tp); run = 1; triggered = trig_in_pre;
    tick();
    run = 0;
    for (int c = 0; c < 400 && !finished; c++) begin
      smpl_en = (c % period) == 0;
      if (armed && !seen_armed) begin seen_armed = 1; arm_rise_addr = int'(waddr); end
      if (armed && (arm_w + int'(smpl_en) >= armed_writes)) triggered = 1;
      if (armed) arm_cyc++;
      tick();
      if (o_we) begin
        total++;
        if (o_armed) arm_w++;
        else if (seen_armed) post_w++;
        else pre_w++;
      end
      if (set_capture_done) sd_n++;
      if (capture_done) finished = 1;
    end
    chk({tag, "_finished"}, finished, 1);
    smpl_en = 0; triggered = 0;
    repeat (2) begin tick(); if (set_capture_done) sd_n++; end
    chk({tag, "_pre_writes"}, pre_w, tp);
    chk({tag, "_arm_rise_waddr"}, arm_rise_addr, tp % E);
    chk({tag, "_post_writes"}, post_w, E - tp);
    chk({tag, "_sd_pulses"}, sd_n, 1);
    chk({tag, "_final_waddr"}, waddr, total % E);
    chk({tag, "_trig_addr"}, trig_addr, (total - (E - tp)) % E);
    if (trig_in_pre) chk({tag, "_armed_cycles"}, arm_cyc, 1);
    if (tp == 4 && armed_writes == 6) begin
      chk({tag, "_trig_addr_10"}, trig_addr, 10);
      chk({tag, "_waddr_6"}, waddr, 6);
    end
    done_ack = 1; tick(); done_ack = 0;
    chk({tag, "_idle_after_ack"}, busy, 0);
  endtask

  initial begin
    int sd_seen;
    //            rst run smp trg ack tp  rep arm bsy cd sd  wa taddr
    tbl[0]  = '{1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 2,  1, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 0, 0,  1, 0, 1, 0, 0, 1, 0};
    tbl[3]  = '{0, 0, 1, 0, 0, 0,  1, 1, 1, 0, 0, 2, 0};
    tbl[4]  = '{0, 0, 1, 1, 0, 0,  1, 0, 1, 0, 0, 3, 3};
    tbl[5]  = '{0, 0, 1, 1, 0, 0, 13, 0, 1, 0, 0, 0, 3};
    tbl[6]  = '{0, 0, 1, 0, 0, 0,  1, 0, 1, 1, 1, 1, 3};
    tbl[7]  = '{0, 1, 1, 0, 0, 5,  1, 0, 1, 1, 0, 1, 3};
    tbl[8]  = '{0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 1, 3};
    tbl[9]  = '{0, 1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 3};
    tbl[10] = '{0, 0, 0, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 0, 0, 16, 0, 1, 1, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};

    idle_inputs();
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; run = tbl[i].run; smpl_en = tbl[i].smpl;
      triggered = tbl[i].trig; done_ack = tbl[i].ack; trig_pos = tbl[i].tp;
      repeat (tbl[i].rep) tick();
      chk_en = 1;
      chk($sformatf("vec%0d_armed", i),     armed,            tbl[i].e_armed);
      chk($sformatf("vec%0d_busy", i),      busy,             tbl[i].e_busy);
      chk($sformatf("vec%0d_cap_done", i),  capture_done,     tbl[i].e_cd);
      chk($sformatf("vec%0d_set_done", i),  set_capture_done, tbl[i].e_sd);
      chk($sformatf("vec%0d_waddr", i),     waddr,            tbl[i].e_waddr);
      chk($sformatf("vec%0d_trig_addr", i), trig_addr,        tbl[i].e_taddr);
    end
    idle_inputs();
    tick();

    do_capture(4,  1, 0, 6, "tp4");
    do_capture(0,  1, 0, 3, "tp0");
    do_capture(15, 1, 0, 1, "tp15");
    do_capture(5,  3, 0, 2, "every3");
    do_capture(3,  1, 1, 0, "trig_in_pre");

    // Reset in the middle of POST: everything clears, no completion pulse afterwards.
    idle_inputs();
    trig_pos = 4'd2; run = 1; tick();
    run = 0; smpl_en = 1; triggered = 1;
    repeat (6) tick();
    chk("midpost_in_post", busy && !armed && !capture_done, 1);
    rst = 1; tick(); rst = 0;
    chk("rst_armed", armed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cap_done", capture_done, 0);
    chk("rst_set_done", set_capture_done, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_trig_addr", trig_addr, 0);
    sd_seen = 0;
    repeat (20) begin tick(); if (set_capture_done || busy) sd_seen++; end
    chk("rst_no_restart", sd_seen, 0);

    // Randomized traffic against the model.
    idle_inputs();
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(299) == 0);
      run       = ($urandom_range(9) == 0);
      smpl_en   = ($urandom_range(1) == 0);
      triggered = ($urandom_range(7) == 0);
      done_ack  = ($urandom_range(5) == 0);
      trig_pos  = AW'($urandom_range(E - 1));
      tick();
    end
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
